seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode 7-segment display. It captures a packed BCD word on `load` and scans one digit per slot. It decodes each digit to active-low segments and adds optional leading-zero blanking, decimal points and display blink. The block sits between the calculator FSM's result/operand registers and the board display pins, and replaces the per-digit combinational BCD decoders.

---
 rtl/seg7_scan_driver_if.sv | 37 +++
 rtl/seg7_scan_driver.sv | 135 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//   Display-side bundle for seg7_scan_driver.
//   master: the producer of digits (calculator FSM or testbench).
//   slave : the scan driver.
//   Signals:
//     bcd_in[4*DIGITS]  packed BCD, digit i at [4i+3:4i], digit 0 is the LSD
//     dp_in[DIGITS]     decimal point request per digit, 1 = lit
//     load              one-cycle strobe, captures bcd_in/dp_in
//     blank_lz          leading-zero blanking enable
//     blink_en          whole-display blink enable
//     seg[7]            segments s0..s6, active-low
//     dp                decimal point, active-low
//     an[DIGITS]        digit enables, active-low
//     frame_tick        one-cycle pulse after the scan wraps to digit 0
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                blank_lz;
  logic                blink_en;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_tick;

  modport master (
    output bcd_in, dp_in, load, blank_lz, blink_en,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  bcd_in, dp_in, load, blank_lz, blink_en,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
//   A BCD/dp snapshot is captured on load; one digit is scanned per
//   CLK_DIV-cycle slot. Each digit is decoded in its own lane, with
//   leading-zero blanking, then the active lane is muxed to the pins.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    seg7_scan_driver_if.slave (bcd_in, dp_in, load, blank_lz,
//            blink_en in; seg, dp, an, frame_tick out, all registered)

// Per-digit decoder: BCD -> active-low segments, seg[0] = s0.
module seg7_digit_lane (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (bcd)
      4'd0: seg = 7'b0001000;
      4'd1: seg = 7'b1101101;
      4'd2: seg = 7'b0100010;
      4'd3: seg = 7'b0100100;
      4'd4: seg = 7'b1000101;
      4'd5: seg = 7'b0010100;
      4'd6: seg = 7'b0010000;
      4'd7: seg = 7'b0101101;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = 7'h7F;
    endcase
    if (blank) seg = 7'h7F;
  end
endmodule

module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input logic             clk,
  input logic             rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int PW = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
  localparam int IW = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIGITS-1:0][3:0] snap_bcd;
  logic [DIGITS-1:0]      snap_dp;
  logic [PW-1:0]          pre;
  logic [IW-1:0]          idx;
  logic [BW-1:0]          bcnt;
  logic                   phase;
  logic                   wrap_q;   // scan wrapped on the previous edge

  logic pre_last, idx_last, wrap;
  assign pre_last = (pre == PW'(CLK_DIV - 1));
  assign idx_last = (idx == IW'(DIGITS - 1));
  assign wrap     = pre_last && idx_last;

  // zero_hi[i]: every snapshot digit from DIGITS-1 down to i is zero.
  logic [DIGITS:1]        zero_hi;
  logic [DIGITS-1:0][6:0] lane_seg;

  assign zero_hi[DIGITS] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lane
    logic lz_blank;
    if (gi == 0) begin : g_lsd
      // The least significant digit always shows, so 0 reads as "0".
      assign lz_blank = 1'b0;
    end else begin : g_upper
      assign zero_hi[gi] = zero_hi[gi+1] && (snap_bcd[gi] == 4'd0);
      assign lz_blank    = bus.blank_lz && zero_hi[gi];
    end
    seg7_digit_lane u_lane (
      .bcd   (snap_bcd[gi]),
      .blank (lz_blank),
      .seg   (lane_seg[gi])
    );
  end

  // Anodes stay off on a slot's first cycle (segments settle) and during
  // the blink-off phase; blink_en is used live so dropping it takes effect
  // on the very next output update.
  logic              an_off;
  logic [DIGITS-1:0] an_scan;
  assign an_off  = (pre == '0) || (bus.blink_en && phase);
  assign an_scan = ~(DIGITS'(1) << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_bcd       <= {DIGITS{4'hF}};
      snap_dp        <= '0;
      pre            <= '0;
      idx            <= '0;
      bcnt           <= '0;
      phase          <= 1'b0;
      wrap_q         <= 1'b0;
      bus.seg        <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.an         <= '1;
      bus.frame_tick <= 1'b0;
    end else begin
      if (bus.load) begin
        snap_bcd <= bus.bcd_in;
        snap_dp  <= bus.dp_in;
      end

      pre <= pre_last ? '0 : pre + PW'(1);
      if (pre_last) idx <= idx_last ? '0 : idx + IW'(1);
      wrap_q <= wrap;

      if (!bus.blink_en) begin
        bcnt  <= '0;
        phase <= 1'b0;
      end else if (wrap) begin
        if (bcnt == BW'(BLINK_FRAMES - 1)) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end

      // Outputs reflect the state as it was before this edge.
      bus.seg        <= lane_seg[idx];
      bus.dp         <= ~snap_dp[idx];
      bus.an         <= an_off ? '1 : an_scan;
      bus.frame_tick <= wrap_q;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
  localparam int D  = 4;
  localparam int C  = 4;
  localparam int BF = 2;
  localparam int FR = C * D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(D)) bus ();

  seg7_scan_driver #(.DIGITS(D), .CLK_DIV(C), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: time-based. k = clock edges since reset release.
  int         k;
  int         k_en;           // edge at which blink_en was first sampled high, -1 if low
  logic [3:0] m_bcd [D];
  logic       m_dp  [D];
  logic [6:0] s_tab [10];     // s0..s6 written left to right

  localparam logic [12:0] RST_OUT = {7'h7F, 1'b1, {D{1'b1}}, 1'b0};

  function automatic logic [6:0] seg_of(input int v);
    logic [6:0] lit;
    logic [6:0] r;
    if (v > 9) return 7'h7F;
    lit = s_tab[v];
    for (int b = 0; b < 7; b++) r[b] = lit[6-b];
    return r;
  endfunction

  function automatic bit model_phase();
    if (k_en < 0) return 1'b0;
    return (((k / FR) - (k_en / FR)) / BF) % 2 == 1;
  endfunction

  function automatic logic [12:0] model_out();
    int         pos, dig;
    bit         blanked;
    logic [6:0] s;
    logic [D-1:0] a;
    logic       tick;
    pos = k % C;
    dig = (k / C) % D;
    blanked = 1'b0;
    if (bus.blank_lz && dig > 0) begin
      blanked = 1'b1;
      for (int j = dig; j < D; j++) if (m_bcd[j] != 4'd0) blanked = 1'b0;
    end
    s = blanked ? 7'h7F : seg_of(int'(m_bcd[dig]));
    a = '1;
    if (!(pos == 0 || (bus.blink_en && model_phase()))) a[dig] = 1'b0;
    tick = (k > 0) && (k % FR == 0);
    return {s, ~m_dp[dig], a, tick};
  endfunction

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s k=%0d seg/dp/an/tick got=%h want=%h", tag, k, got, want);
    end
  endtask

  function automatic logic [12:0] dut_out();
    return {bus.seg, bus.dp, bus.an, bus.frame_tick};
  endfunction

  // One clock edge: predict, clock, update model, check.
  task automatic step(input string tag);
    logic [12:0] want;
    if (!bus.blink_en)   k_en = -1;
    else if (k_en < 0)   k_en = k;
    want = model_out();
    @(posedge clk);
    if (bus.load) begin
      for (int i = 0; i < D; i++) begin
        m_bcd[i] = bus.bcd_in[4*i +: 4];
        m_dp[i]  = bus.dp_in[i];
      end
    end
    k++;
    #1;
    chk(tag, dut_out(), want);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input string tag);
    bus.bcd_in = v;
    bus.dp_in  = d;
    bus.load   = 1'b1;
    step(tag);
    bus.load   = 1'b0;
  endtask

  task automatic model_reset();
    k    = 0;
    k_en = -1;
    for (int i = 0; i < D; i++) begin
      m_bcd[i] = 4'hF;
      m_dp[i]  = 1'b0;
    end
  endtask

  initial begin
    s_tab[0] = 7'b0001000; s_tab[1] = 7'b1011011; s_tab[2] = 7'b0100010;
    s_tab[3] = 7'b0010010; s_tab[4] = 7'b1010001; s_tab[5] = 7'b0010100;
    s_tab[6] = 7'b0000100; s_tab[7] = 7'b1011010; s_tab[8] = 7'b0000000;
    s_tab[9] = 7'b0010000;
    bus.bcd_in   = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;
    model_reset();

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", dut_out(), RST_OUT);
    end
    @(negedge clk) rst_n = 1'b1;
    run("idle_scan", 20);

    // Decode and scan
    do_load(16'h1234, 4'b0010, "load_1234");
    run("scan_1234", 40);

    // Leading-zero blanking
    bus.blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000, "load_0070");
    run("lz_0070", 16);
    do_load(16'h0000, 4'b0100, "load_0000");
    run("lz_0000", 16);
    bus.blank_lz = 1'b0;
    run("nolz_0000", 16);

    // Invalid codes
    do_load(16'hA0F9, 4'b1001, "load_a0f9");
    run("invalid", 16);

    // Blink: align to a frame boundary, enable, watch on/off/on
    for (int i = 0; i < FR && (k % FR) != 0; i++) step("blink_align");
    bus.blink_en = 1'b1;
    run("blink", 100);
    for (int i = 0; i < 4 * FR && !model_phase(); i++) step("blink_wait_off");
    run("blink_off", 5);
    bus.blink_en = 1'b0;
    run("blink_drop", 12);

    // Load in the 3rd cycle of digit 0's slot
    for (int i = 0; i < FR && (k % FR) != 2; i++) step("mid_align");
    do_load(16'h5678, 4'b0001, "load_mid");
    run("after_mid", 20);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [15:0] v;
      for (int n = 0; n < D; n++)
        v[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.bcd_in = v;
      bus.dp_in  = 4'($urandom_range(0, 15));
      bus.load   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
      if ($urandom_range(0, 63) == 0) bus.blink_en = ~bus.blink_en;
      step("random");
    end
    bus.load     = 1'b0;
    bus.blink_en = 1'b0;

    // Asynchronous reset mid-frame
    run("pre_rst", 7);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", dut_out(), RST_OUT);
    model_reset();
    @(negedge clk);
    chk("rst_held", dut_out(), RST_OUT);
    rst_n = 1'b1;
    run("post_rst_blank", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
